// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator window sampler.
// Result bundle pairs a window sum with its truncated mean.
package acc_pkg;

  localparam int ACC_DATA_WD  = 32;
  localparam int ACC_LOG2_WIN = 4;
  localparam int WIN_LEN      = 2 ** ACC_LOG2_WIN;
  localparam int SUM_WD       = ACC_DATA_WD + ACC_LOG2_WIN;

  typedef struct packed {
    logic [SUM_WD-1:0]      sum;
    logic [ACC_DATA_WD-1:0] mean;
  } acc_win_res_t;

endpackage

// File: rtl/acc_result_fifo.sv
// Small synchronous result FIFO with a registered head entry.
// Head register is refreshed on push-into-empty and on pop.
module acc_result_fifo
  import acc_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = acc_win_res_t
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  T              mem [FIFO_DEPTH];
  T              head_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);
  assign head    = head_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_nxt;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      // Next head is either the incoming entry or the one behind the popped head
      if (empty && do_push)
        head_q <= din;
      else if (do_pop) begin
        if (cnt == (AW+1)'(1)) begin
          if (do_push)
            head_q <= din;
        end else
          head_q <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/acc_window_sampler.sv
// Turns an accumulator running total into per-window sum/mean results.
// Window sums are snapshot differences, so accumulator wrap is harmless.
module acc_window_sampler
  import acc_pkg::*;
#(
  parameter int DATA_WD    = 32,
  parameter int ACC_WD     = 64,
  parameter int LOG2_WIN   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_enable,
  input  logic [ACC_WD-1:0]          i_acc_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WD+LOG2_WIN-1:0] o_sum,
  output logic [DATA_WD-1:0]         o_mean,
  output logic                       o_overrun,
  input  logic                       i_clr_ovr
);

  localparam int SUM_W = DATA_WD + LOG2_WIN;

  typedef struct packed {
    logic [SUM_W-1:0]   sum;
    logic [DATA_WD-1:0] mean;
  } res_t;

  logic [LOG2_WIN-1:0] cnt;
  logic                cap_pend;
  logic [ACC_WD-1:0]   snap;
  logic [ACC_WD-1:0]   diff;
  logic                ovr;
  logic                full;
  logic                empty;
  logic                pop;
  logic                drop;
  res_t                res;
  res_t                head;

  assign diff     = i_acc_data - snap;
  assign res.sum  = diff[SUM_W-1:0];
  assign res.mean = diff[SUM_W-1:LOG2_WIN];

  generate
    if (ACC_WD > SUM_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^diff[ACC_WD-1:SUM_W];
    end
  endgenerate

  assign pop  = !empty && i_ready;
  assign drop = cap_pend && full && !pop;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt      <= '0;
      cap_pend <= 1'b0;
      snap     <= '0;
      ovr      <= 1'b0;
    end else begin
      if (i_enable)
        cnt <= cnt + LOG2_WIN'(1);
      cap_pend <= i_enable && (&cnt);
      // Snapshot moves even when the result is dropped
      if (cap_pend)
        snap <= i_acc_data;
      if (drop)
        ovr <= 1'b1;
      else if (i_clr_ovr)
        ovr <= 1'b0;
    end
  end

  acc_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (res_t)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .push   (cap_pend),
    .din    (res),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  assign o_valid   = !empty;
  assign o_sum     = head.sum;
  assign o_mean    = head.mean;
  assign o_overrun = ovr;

endmodule

// File: doc/acc_window_sampler.md
Name: acc_window_sampler

Overview:
Downstream companion to the free-running accumulator. It consumes the accumulator's registered running total and the same enable that drives it. Every 2^LOG2_WIN enabled samples it emits one result: the window sum (the difference between successive total snapshots, so accumulator wrap is harmless) and the window mean (sum >> LOG2_WIN). Results go out on a valid/ready stream through a small result FIFO, with sticky overrun reporting.

Parameters:
DATA_WD, 32, width of samples fed to the accumulator
ACC_WD, 64, width of the accumulator total; must satisfy DATA_WD+LOG2_WIN <= ACC_WD
LOG2_WIN, 4, log2 of the window length N (N = 2^LOG2_WIN, LOG2_WIN >= 1)
FIFO_DEPTH, 2, result FIFO entries (power of 2, >= 2)

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset, shared with the accumulator
i_enable  input  1  same enable the accumulator sees; one sample per high cycle
i_acc_data  input  ACC_WD  accumulator total (the accumulator's o_data)
o_valid  output  1  result available
i_ready  input  1  consumer accepts result when o_valid && i_ready
o_sum  output  DATA_WD+LOG2_WIN  window sum of the head result
o_mean  output  DATA_WD  window mean of the head result (truncating)
o_overrun  output  1  sticky: a result was dropped because the FIFO was full
i_clr_ovr  input  1  synchronous clear of o_overrun

Behaviour:
- Reset (async assert, sync release): sample count=0, snapshot=0, capture_pend=0, FIFO empty, o_valid=0, o_sum=0, o_mean=0, o_overrun=0. This matches the accumulator's reset total of 0, so the first window needs no special case.
- Counter (LOG2_WIN bits): increments on each i_enable cycle and wraps N-1 -> 0. Idle cycles (i_enable=0) do not count; gaps are allowed anywhere.
- Cycle t, i_enable=1 and count==N-1: set capture_pend at edge t+1.
- Cycle t+1: i_acc_data already includes sample N. With capture_pend=1:
  - diff = (i_acc_data - snapshot) mod 2^ACC_WD; o_sum field = diff[DATA_WD+LOG2_WIN-1:0].
  - mean = diff[DATA_WD+LOG2_WIN-1:LOG2_WIN].
  - snapshot <= i_acc_data. Push {sum, mean} at edge t+2. capture_pend clears.
- Latency: o_valid rises after edge t+2, i.e. 2 cycles after the cycle carrying the Nth enable. Back-to-back windows (continuous enable) produce one push every N cycles.
- Snapshot update is unconditional on capture, even when the push is dropped, so later windows stay correct.
- FIFO rules:
  - o_valid = !empty; o_sum and o_mean come from the head entry, registered, with no combinational path from i_ready.
  - Pop on o_valid && i_ready. Outputs hold stable while o_valid && !i_ready.
  - Push when full and no pop that cycle: the result is dropped and o_overrun <= 1.
  - Push when full with a pop in the same cycle: both happen and there is no overrun.
  - Push when empty: o_valid rises next cycle (no bypass).
- o_overrun: set has priority over i_clr_ovr in the same cycle.
- Wrap-around: the modular subtraction gives the correct window sum across accumulator wrap at 2^ACC_WD.
- Reset mid-window discards the partial count, any pending capture and all FIFO contents. The accumulator resets on the same i_rstn, so alignment is preserved.

Decomposition:
- Package acc_pkg:
  - localparams: WIN_LEN = 2**LOG2_WIN and SUM_WD = DATA_WD+LOG2_WIN (defaults mirrored there for shared use).
  - typedef struct packed acc_win_res_t {sum, mean}.
- One sub-module: acc_result_fifo, a synchronous FIFO of acc_win_res_t with push, pop, full, empty and registered head, parameterised by FIFO_DEPTH.
- Counter, snapshot and overrun logic live in the top level.

Test Plan:
- LOG2_WIN=2, DATA_WD=32, ACC_WD=64, i_ready=1, enable continuous with data 1,2,3,4 (bench instantiates the accumulator) -> o_valid pulses one cycle, 2 cycles after the 4th sample cycle, with o_sum=10, o_mean=2.
- Same config, data 5,0,0,7,1,1,1,1 with idle gaps between samples -> two results: (sum 12, mean 3) then (sum 4, mean 1); idle cycles do not advance the count.
- ACC_WD=36, LOG2_WIN=2, data continuously 0xFFFFFFFF for 24 samples -> six results, each o_sum=0x3_FFFF_FFFC and o_mean=0xFFFFFFFF, correct across the accumulator wrap.
- i_ready=0, FIFO_DEPTH=2, three windows completed -> first two held with stable outputs, third dropped, o_overrun=1. Raise i_ready -> first two results drain in order; pulse i_clr_ovr -> o_overrun=0.
- FIFO full, i_ready=1 in exactly the capture-push cycle -> head pops and the new result enqueues; o_overrun stays 0.
- Assert i_rstn low after 2 samples of a window, then release and feed 1,1,1,1 -> o_sum=4, o_mean=1; no stale result appears.
